// File: rtl/usb_rx_decoder.sv
// Full-speed USB receive front end: line synchronizer, NRZI decode, sync search,
// bit unstuffing, PID decode, EOP detection and a CRC-hiding payload delay buffer.
module usb_rx_decoder (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    output logic [2:0] rx_packet,
    output logic       store_rx_packet,
    output logic [7:0] rx_packet_data
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        BODY,
        WAIT_EOP
    } state_t;

    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_DATA  = 3'd2;
    localparam logic [2:0] CODE_ERROR = 3'd7;

    state_t     state;
    logic       dplus_meta;
    logic       dplus_sync;
    logic       dminus_meta;
    logic       dminus_sync;
    logic       prev_level;
    logic [6:0] sync_shift;
    logic [6:0] shift_byte;
    logic [2:0] bit_cnt;
    logic [2:0] ones_cnt;
    logic [7:0] pid_byte;
    logic       pid_pending;
    logic       is_data;
    logic [7:0] buf_old;
    logic [7:0] buf_new;
    logic [1:0] buf_cnt;

    logic       line_se0;
    logic       dec_bit;
    logic [7:0] sync_next;
    logic [7:0] byte_next;
    logic       stuff_slot;
    logic       byte_done;
    logic [2:0] pid_code;

    function automatic logic [2:0] decode_pid(input logic [7:0] pid);
        logic [2:0] code;
        case (pid)
            8'hE1:        code = 3'd1;
            8'h69:        code = 3'd3;
            8'hC3, 8'h4B: code = 3'd2;
            8'hD2:        code = 3'd4;
            8'h5A:        code = 3'd5;
            8'h1E:        code = 3'd6;
            default:      code = CODE_ERROR;
        endcase
        return code;
    endfunction

    // J and K are told apart by D+ alone; equal levels on both lines count as SE0.
    assign line_se0   = (dplus_sync == dminus_sync);
    assign dec_bit    = (dplus_sync == prev_level);
    assign sync_next  = {sync_shift, dec_bit};
    assign byte_next  = {shift_byte, dec_bit};
    assign stuff_slot = (ones_cnt == 3'd6);
    assign byte_done  = !stuff_slot && (bit_cnt == 3'd7);
    assign pid_code   = decode_pid(pid_byte);

    // After SE0 the line is assumed to return to J, so the reference level is reset to J.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dplus_meta  <= 1'b1;
            dplus_sync  <= 1'b1;
            dminus_meta <= 1'b0;
            dminus_sync <= 1'b0;
            prev_level  <= 1'b1;
        end else begin
            dplus_meta  <= dplus_in;
            dplus_sync  <= dplus_meta;
            dminus_meta <= dminus_in;
            dminus_sync <= dminus_meta;
            prev_level  <= line_se0 ? 1'b1 : dplus_sync;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            rx_packet       <= CODE_NONE;
            store_rx_packet <= 1'b0;
            rx_packet_data  <= 8'h00;
            sync_shift      <= 7'h7F;
            shift_byte      <= 7'h00;
            bit_cnt         <= 3'd0;
            ones_cnt        <= 3'd0;
            pid_byte        <= 8'h00;
            pid_pending     <= 1'b0;
            is_data         <= 1'b0;
            buf_old         <= 8'h00;
            buf_new         <= 8'h00;
            buf_cnt         <= 2'd0;
        end else begin
            store_rx_packet <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_se0) begin
                        sync_shift <= 7'h7F;
                    end else begin
                        sync_shift <= sync_next[6:0];
                        if (!dec_bit) begin
                            state <= SYNC;
                        end
                    end
                end

                SYNC: begin
                    if (line_se0) begin
                        state      <= IDLE;
                        sync_shift <= 7'h7F;
                    end else if (sync_next == 8'h01) begin
                        // The closing 1 of the sync pattern already counts towards a stuffing run.
                        state       <= PID;
                        rx_packet   <= CODE_NONE;
                        sync_shift  <= 7'h7F;
                        shift_byte  <= 7'h00;
                        bit_cnt     <= 3'd0;
                        ones_cnt    <= 3'd1;
                        pid_pending <= 1'b0;
                        is_data     <= 1'b0;
                        buf_cnt     <= 2'd0;
                    end else if (sync_next == 8'hFF) begin
                        state      <= IDLE;
                        sync_shift <= 7'h7F;
                    end else begin
                        sync_shift <= sync_next[6:0];
                    end
                end

                PID, BODY: begin
                    // PID code lands one cycle after its byte; later error/EOP assignments override it.
                    if (pid_pending) begin
                        pid_pending <= 1'b0;
                        rx_packet   <= pid_code;
                        is_data     <= (pid_code == CODE_DATA);
                        if (pid_code == CODE_ERROR) begin
                            state <= WAIT_EOP;
                        end
                    end

                    if (line_se0) begin
                        state       <= IDLE;
                        pid_pending <= 1'b0;
                        buf_cnt     <= 2'd0;
                        if ((state == PID) || (bit_cnt != 3'd0)) begin
                            rx_packet <= CODE_ERROR;
                        end
                    end else if (stuff_slot) begin
                        if (dec_bit) begin
                            state       <= WAIT_EOP;
                            rx_packet   <= CODE_ERROR;
                            pid_pending <= 1'b0;
                        end else begin
                            ones_cnt <= 3'd0;
                        end
                    end else begin
                        shift_byte <= byte_next[6:0];
                        bit_cnt    <= bit_cnt + 3'd1;
                        ones_cnt   <= dec_bit ? ones_cnt + 3'd1 : 3'd0;
                        if (byte_done) begin
                            if (state == PID) begin
                                state       <= BODY;
                                pid_byte    <= byte_next;
                                pid_pending <= 1'b1;
                            end else if (is_data) begin
                                // Two-byte delay keeps the trailing CRC16 from ever being stored.
                                case (buf_cnt)
                                    2'd0: begin
                                        buf_old <= byte_next;
                                        buf_cnt <= 2'd1;
                                    end
                                    2'd1: begin
                                        buf_new <= byte_next;
                                        buf_cnt <= 2'd2;
                                    end
                                    default: begin
                                        rx_packet_data  <= buf_old;
                                        store_rx_packet <= 1'b1;
                                        buf_old         <= buf_new;
                                        buf_new         <= byte_next;
                                    end
                                endcase
                            end
                        end
                    end
                end

                WAIT_EOP: begin
                    if (line_se0) begin
                        state      <= IDLE;
                        sync_shift <= 7'h7F;
                        buf_cnt    <= 2'd0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: drives NRZI-encoded, bit-stuffed packets on D+/D- and
// compares stored payload bytes against a queue filled as the packets are sent.
module tb_usb_rx_decoder;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       dplus_in;
    logic       dminus_in;
    logic [2:0] rx_packet;
    logic       store_rx_packet;
    logic [7:0] rx_packet_data;

    int         total = 0;
    int         bad = 0;
    int         pulses = 0;
    int         ones = 0;
    logic       cur_level = 1'b1;
    logic [7:0] exp_q[$];

    usb_rx_decoder dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .dplus_in       (dplus_in),
        .dminus_in      (dminus_in),
        .rx_packet      (rx_packet),
        .store_rx_packet(store_rx_packet),
        .rx_packet_data (rx_packet_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every stored byte must match the oldest payload byte still owed.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && store_rx_packet !== 1'b0) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_store", 32'd1, 32'd0);
            end else begin
                checkOutput("store_data", {24'd0, rx_packet_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic putLine(input logic dp, input logic dm);
        dplus_in  = dp;
        dminus_in = dm;
        @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b, input bit stuff);
        if (!b) cur_level = ~cur_level;
        putLine(cur_level, ~cur_level);
        ones = b ? ones + 1 : 0;
        if (stuff && ones == 6) begin
            cur_level = ~cur_level;
            putLine(cur_level, ~cur_level);
            ones = 0;
        end
    endtask

    task automatic sendByte(input logic [7:0] value);
        for (int i = 7; i >= 0; i--) sendBit(value[i], 1'b1);
    endtask

    task automatic sendSync();
        cur_level = 1'b1;
        ones = 0;
        for (int i = 0; i < 7; i++) sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
    endtask

    task automatic sendEop();
        putLine(1'b0, 1'b0);
        cur_level = 1'b1;
        ones = 0;
        repeat (4) putLine(1'b1, 1'b0);
    endtask

    // Sync, PID, then nbytes body bytes taken MSB-first from body; the first nstore are owed as stores.
    task automatic applyStimulus(input logic [7:0] pid, input logic [31:0] body, input int nbytes, input int nstore);
        logic [31:0] rest;
        rest = body;
        sendSync();
        sendByte(pid);
        for (int i = 0; i < nbytes; i++) begin
            if (i < nstore) exp_q.push_back(rest[31:24]);
            sendByte(rest[31:24]);
            rest = rest << 8;
        end
    endtask

    initial begin
        logic [7:0] tok_pid [4];
        logic [2:0] tok_code [4];
        tok_pid  = '{8'hE1, 8'hD2, 8'h5A, 8'h1E};
        tok_code = '{3'd1, 3'd4, 3'd5, 3'd6};

        n_rst = 1'b0;
        dplus_in = 1'b1;
        dminus_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_packet", {29'd0, rx_packet}, 32'd0);
        checkOutput("rst_store", {31'd0, store_rx_packet}, 32'd0);
        checkOutput("rst_data", {24'd0, rx_packet_data}, 32'd0);
        n_rst = 1'b1;
        repeat (2) putLine(1'b1, 1'b0);
        checkOutput("idle_packet", {29'd0, rx_packet}, 32'd0);
        checkOutput("idle_store", {31'd0, store_rx_packet}, 32'd0);
        checkOutput("idle_data", {24'd0, rx_packet_data}, 32'd0);

        applyStimulus(8'h69, 32'hCD77_0000, 2, 0);
        checkOutput("in_pre_eop", {29'd0, rx_packet}, 32'd3);
        sendEop();
        checkOutput("in_post_eop", {29'd0, rx_packet}, 32'd3);

        for (int t = 0; t < 4; t++) begin
            applyStimulus(tok_pid[t], 32'h0, 0, 0);
            sendEop();
            checkOutput($sformatf("pid_%0h", tok_pid[t]), {29'd0, rx_packet}, {29'd0, tok_code[t]});
        end

        applyStimulus(8'hB4, 32'h1234_0000, 2, 0);
        checkOutput("bad_pid_pre_eop", {29'd0, rx_packet}, 32'd7);
        sendEop();
        checkOutput("bad_pid_post_eop", {29'd0, rx_packet}, 32'd7);

        sendSync();
        sendBit(1'b1, 1'b1);
        sendBit(1'b1, 1'b1);
        sendBit(1'b0, 1'b1);
        checkOutput("sync_clear", {29'd0, rx_packet}, 32'd0);
        sendEop();
        checkOutput("short_pid", {29'd0, rx_packet}, 32'd7);

        applyStimulus(8'hD2, 32'h0, 0, 0);
        repeat (3) sendBit(1'b1, 1'b1);
        checkOutput("ack_before_cut", {29'd0, rx_packet}, 32'd4);
        sendEop();
        checkOutput("midbyte_eop", {29'd0, rx_packet}, 32'd7);

        pulses = 0;
        applyStimulus(8'hC3, 32'hA53C_5EE1, 4, 2);
        sendEop();
        checkOutput("data0_pulses", pulses, 32'd2);
        checkOutput("data0_packet", {29'd0, rx_packet}, 32'd2);
        checkOutput("data0_queue", exp_q.size(), 32'd0);

        pulses = 0;
        applyStimulus(8'h4B, 32'hFFFF_0000, 4, 2);
        sendEop();
        checkOutput("stuff_pulses", pulses, 32'd2);
        checkOutput("stuff_packet", {29'd0, rx_packet}, 32'd2);

        pulses = 0;
        sendSync();
        sendByte(8'h4B);
        repeat (8) sendBit(1'b1, 1'b0);
        checkOutput("stuff_err", {29'd0, rx_packet}, 32'd7);
        sendEop();
        checkOutput("stuff_err_eop", {29'd0, rx_packet}, 32'd7);
        checkOutput("stuff_err_pulses", pulses, 32'd0);

        applyStimulus(8'hC3, 32'h1122_3300, 3, 1);
        repeat (4) sendBit(1'b0, 1'b1);
        checkOutput("pre_rst_data", {24'd0, rx_packet_data}, 32'h11);
        #3;
        n_rst = 1'b0;
        #1;
        checkOutput("async_rst_packet", {29'd0, rx_packet}, 32'd0);
        checkOutput("async_rst_store", {31'd0, store_rx_packet}, 32'd0);
        checkOutput("async_rst_data", {24'd0, rx_packet_data}, 32'd0);
        cur_level = 1'b1;
        ones = 0;
        dplus_in = 1'b1;
        dminus_in = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        n_rst = 1'b1;
        repeat (3) putLine(1'b1, 1'b0);

        applyStimulus(8'hD2, 32'h0, 0, 0);
        sendEop();
        checkOutput("ack_after_rst", {29'd0, rx_packet}, 32'd4);
        checkOutput("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
